// File: rtl/e203_dtcm_ram_ctrl_pkg.sv
// Shared DTCM RAM controller definitions: power-state encoding and tie-off constants.
package e203_dtcm_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        PWR_RUN   = 2'd0,
        PWR_SLEEP = 2'd1,
        PWR_WAKE  = 2'd2
    } pwr_state_t;

    localparam logic RAM_LS_OFF = 1'b0;
    localparam logic RAM_DS_TIE = 1'b0;
    localparam logic RAM_SD_TIE = 1'b0;

endpackage

// File: rtl/e203_dtcm_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, last-grant history moves only on upd.
module e203_dtcm_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    logic last_b;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_b ? 2'b01 : 2'b10;
        end
    end

    // Reset history to B so that A takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (upd) begin
            last_b <= gnt[1];
        end
    end

endmodule

// File: rtl/e203_dtcm_ram_ctrl.sv
// Two-requester DTCM SRAM controller: 1-cycle response with 1-entry stall buffer.
// Light-sleep power FSM enabled by macro E203_DTCM_RAM_LS_EN.
module e203_dtcm_ram_ctrl #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int IDLE_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_cmd_valid,
    output logic          a_cmd_ready,
    input  logic          a_cmd_read,
    input  logic [AW-1:0] a_cmd_addr,
    input  logic [DW-1:0] a_cmd_wdata,
    input  logic [MW-1:0] a_cmd_wmask,
    output logic          a_rsp_valid,
    input  logic          a_rsp_ready,
    output logic [DW-1:0] a_rsp_rdata,
    input  logic          b_cmd_valid,
    output logic          b_cmd_ready,
    input  logic          b_cmd_read,
    input  logic [AW-1:0] b_cmd_addr,
    input  logic [DW-1:0] b_cmd_wdata,
    input  logic [MW-1:0] b_cmd_wmask,
    output logic          b_rsp_valid,
    input  logic          b_rsp_ready,
    output logic [DW-1:0] b_rsp_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    import e203_dtcm_ram_ctrl_pkg::*;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          win_b;
    logic          win_rd;
    logic          pwr_run;
    logic          cmd_ok;
    logic          accept;

    logic          p_vld;
    logic          rsp_id;
    logic          rsp_rd;
    logic          buf_vld;
    logic [DW-1:0] buf_dat;
    logic          rsp_any;
    logic          rsp_hs;
    logic [DW-1:0] live_dat;
    logic [DW-1:0] rsp_dat;

    assign req = {b_cmd_valid, a_cmd_valid};

    e203_dtcm_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .upd (accept),
        .gnt (gnt)
    );

    // A response is outstanding from the cycle after accept until its handshake.
    assign rsp_any  = p_vld | buf_vld;
    assign rsp_hs   = rsp_any & (rsp_id ? b_rsp_ready : a_rsp_ready);
    assign live_dat = rsp_rd ? ram_dout : '0;
    assign rsp_dat  = buf_vld ? buf_dat : live_dat;

    assign a_rsp_valid = rsp_any & ~rsp_id;
    assign b_rsp_valid = rsp_any &  rsp_id;
    assign a_rsp_rdata = rsp_dat;
    assign b_rsp_rdata = rsp_dat;

    assign cmd_ok      = pwr_run & (~rsp_any | rsp_hs);
    assign a_cmd_ready = cmd_ok & gnt[0];
    assign b_cmd_ready = cmd_ok & gnt[1];
    assign accept      = cmd_ok & (|req);

    assign win_b    = gnt[1];
    assign win_rd   = win_b ? b_cmd_read : a_cmd_read;
    assign ram_cs   = accept;
    assign ram_we   = accept & ~win_rd;
    assign ram_addr = win_b ? b_cmd_addr  : a_cmd_addr;
    assign ram_din  = win_b ? b_cmd_wdata : a_cmd_wdata;
    assign ram_wem  = ram_we ? (win_b ? b_cmd_wmask : a_cmd_wmask) : '0;
    assign ram_ds   = RAM_DS_TIE;
    assign ram_sd   = RAM_SD_TIE;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld   <= 1'b0;
            rsp_id  <= 1'b0;
            rsp_rd  <= 1'b0;
            buf_vld <= 1'b0;
            buf_dat <= '0;
        end else begin
            p_vld <= accept;
            if (accept) begin
                rsp_id <= win_b;
                rsp_rd <= win_rd;
            end
            // SRAM output is only valid in the response cycle; park it if stalled.
            if (p_vld && !rsp_hs) begin
                buf_vld <= 1'b1;
                buf_dat <= live_dat;
            end else if (buf_vld && rsp_hs) begin
                buf_vld <= 1'b0;
            end
        end
    end

`ifdef E203_DTCM_RAM_LS_EN
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);

    pwr_state_t state_q;
    pwr_state_t state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       idle;

    assign idle = ~(|req) & ~rsp_any;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PWR_RUN: begin
                if (!idle) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = PWR_SLEEP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PWR_SLEEP: begin
                if (|req) begin
                    state_d = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                state_d = PWR_RUN;
            end
            default: begin
                state_d = PWR_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PWR_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwr_run = (state_q == PWR_RUN);
    assign ram_ls  = (state_q == PWR_SLEEP);
`else
    logic unused_idle_cyc;

    assign unused_idle_cyc = IDLE_CYC[0];
    assign pwr_run         = 1'b1;
    assign ram_ls          = RAM_LS_OFF;
`endif

endmodule

// File: tb/tb_e203_dtcm_ram_ctrl.sv
// Bench for e203_dtcm_ram_ctrl: SRAM model, transaction-level reference model, directed vectors.
module tb_e203_dtcm_ram_ctrl;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int MW   = 4;
    localparam int IDLE = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_cmd_valid, a_cmd_ready, a_cmd_read;
    logic [AW-1:0] a_cmd_addr;
    logic [DW-1:0] a_cmd_wdata;
    logic [MW-1:0] a_cmd_wmask;
    logic          a_rsp_valid, a_rsp_ready;
    logic [DW-1:0] a_rsp_rdata;
    logic          b_cmd_valid, b_cmd_ready, b_cmd_read;
    logic [AW-1:0] b_cmd_addr;
    logic [DW-1:0] b_cmd_wdata;
    logic [MW-1:0] b_cmd_wmask;
    logic          b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] b_rsp_rdata;
    logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    e203_dtcm_ram_ctrl #(.AW(AW), .DW(DW), .MW(MW), .IDLE_CYC(IDLE)) dut (
        .clk(clk), .rst(rst),
        .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready), .a_cmd_read(a_cmd_read),
        .a_cmd_addr(a_cmd_addr), .a_cmd_wdata(a_cmd_wdata), .a_cmd_wmask(a_cmd_wmask),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready), .b_cmd_read(b_cmd_read),
        .b_cmd_addr(b_cmd_addr), .b_cmd_wdata(b_cmd_wdata), .b_cmd_wmask(b_cmd_wmask),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Synchronous SRAM: read data appears the cycle after cs; garbage otherwise.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            for (int i = 0; i < MW; i++)
                if (ram_wem[i]) mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
            ram_dout <= $urandom;
        end else if (ram_cs) begin
            ram_dout <= mem[ram_addr];
        end else begin
            ram_dout <= $urandom;
        end
    end

    // Reference model: shadow memory, one outstanding response, round-robin history, power mode.
    logic [DW-1:0] sm [0:(1<<AW)-1];
    bit            m_ok = 0;
    bit            m_last, m_pend, m_pid;
    logic [DW-1:0] m_pdat;
    int            m_mode, m_idle;   // mode 0=run 1=sleep 2=wake

    always @(negedge clk) begin
        bit hs, ok, acc, win, idle, w_rd;
        logic [AW-1:0] w_ad;
        logic [DW-1:0] w_wd;
        logic [MW-1:0] w_m;
        hs   = m_pend && (m_pid ? b_rsp_ready : a_rsp_ready);
        ok   = (m_mode == 0) && (!m_pend || hs);
        acc  = ok && (a_cmd_valid || b_cmd_valid);
        win  = (a_cmd_valid && b_cmd_valid) ? !m_last : b_cmd_valid;
        w_rd = win ? b_cmd_read  : a_cmd_read;
        w_ad = win ? b_cmd_addr  : a_cmd_addr;
        w_wd = win ? b_cmd_wdata : a_cmd_wdata;
        w_m  = win ? b_cmd_wmask : a_cmd_wmask;
        if (m_ok) begin
            chk("m_a_cmd_ready", 32'(a_cmd_ready), 32'(acc && !win));
            chk("m_b_cmd_ready", 32'(b_cmd_ready), 32'(acc && win));
            chk("m_ram_cs", 32'(ram_cs), 32'(acc));
            chk("m_ram_ls", 32'(ram_ls), 32'(m_mode == 1));
            chk("m_cs_vs_ls", 32'(ram_cs && ram_ls), 32'd0);
            chk("m_a_rsp_valid", 32'(a_rsp_valid), 32'(m_pend && !m_pid));
            chk("m_b_rsp_valid", 32'(b_rsp_valid), 32'(m_pend && m_pid));
            if (m_pend && !m_pid) chk("m_a_rsp_rdata", a_rsp_rdata, m_pdat);
            if (m_pend && m_pid)  chk("m_b_rsp_rdata", b_rsp_rdata, m_pdat);
            if (acc) chk("m_ram_we", 32'(ram_we), 32'(!w_rd));
        end
        if (rst) begin
            m_ok = 1; m_last = 1; m_pend = 0; m_pid = 0; m_pdat = '0;
            m_mode = 0; m_idle = 0;
        end else if (m_ok) begin
            idle = !a_cmd_valid && !b_cmd_valid && !m_pend;
            if (hs) m_pend = 0;
            if (acc) begin
                if (!w_rd)
                    for (int i = 0; i < MW; i++)
                        if (w_m[i]) sm[w_ad][i*8 +: 8] = w_wd[i*8 +: 8];
                m_pend = 1;
                m_pid  = win;
                m_pdat = w_rd ? sm[w_ad] : '0;
                m_last = win;
            end
`ifdef E203_DTCM_RAM_LS_EN
            case (m_mode)
                0: if (idle) begin
                       m_idle++;
                       if (m_idle == IDLE) begin m_mode = 1; m_idle = 0; end
                   end else m_idle = 0;
                1: if (a_cmd_valid || b_cmd_valid) m_mode = 2;
                default: m_mode = 0;
            endcase
`else
            if (idle) m_idle++;
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic set_a(input logic v, input logic rd, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [MW-1:0] m);
        a_cmd_valid = v; a_cmd_read = rd; a_cmd_addr = ad; a_cmd_wdata = wd; a_cmd_wmask = m;
    endtask

    task automatic set_b(input logic v, input logic rd, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [MW-1:0] m);
        b_cmd_valid = v; b_cmd_read = rd; b_cmd_addr = ad; b_cmd_wdata = wd; b_cmd_wmask = m;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            sm[i]  = '0;
        end
        rst = 1'b1;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        set_a(0, 0, '0, '0, '0);
        set_b(0, 0, '0, '0, '0);
        repeat (3) step();
        look();
        chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("rst_ram_ls", 32'(ram_ls), 32'd0);
        chk("rst_ram_cs", 32'(ram_cs), 32'd0);
        chk("rst_ram_ds_sd", 32'({ram_ds, ram_sd}), 32'd0);

        // write then read back
        step(); rst = 0; set_a(1, 0, 14'h10, 32'hDEADBEEF, 4'hF);
        look(); chk("wr_a_ready", 32'(a_cmd_ready), 32'd1);
        step(); set_a(1, 1, 14'h10, '0, '0);
        look(); chk("wr_rsp_zero", a_rsp_rdata, 32'd0);
                chk("rd_a_ready", 32'(a_cmd_ready), 32'd1);
        step(); set_a(0, 0, '0, '0, '0);
        look(); chk("rd_rsp_valid", 32'(a_rsp_valid), 32'd1);
                chk("rd_rsp_data", a_rsp_rdata, 32'hDEADBEEF);

        // partial byte-mask write
        step(); set_b(1, 0, 14'h20, 32'hFFFFFFFF, 4'hF);
        look();
        step(); set_b(0, 0, '0, '0, '0); set_a(1, 0, 14'h20, 32'hAAAA5555, 4'h3);
        look(); chk("mask_a_ready", 32'(a_cmd_ready), 32'd1);
        step(); set_a(0, 0, '0, '0, '0); set_b(1, 1, 14'h20, '0, '0);
        look(); chk("mask_b_ready", 32'(b_cmd_ready), 32'd1);
        step(); set_b(0, 0, '0, '0, '0);
        look(); chk("mask_rdata", b_rsp_rdata, 32'hFFFF5555);

        // response stall: data held, no new accepts
        step(); set_a(1, 1, 14'h10, '0, '0); a_rsp_ready = 0;
        look(); chk("stall_accept", 32'(a_cmd_ready), 32'd1);
        step(); set_b(1, 1, 14'h20, '0, '0);
        for (int k = 0; k < 3; k++) begin
            look();
            chk("stall_valid", 32'(a_rsp_valid), 32'd1);
            chk("stall_rdata", a_rsp_rdata, 32'hDEADBEEF);
            chk("stall_rdy", 32'({a_cmd_ready, b_cmd_ready}), 32'd0);
            step();
        end
        a_rsp_ready = 1;
        look(); chk("hs_rdata", a_rsp_rdata, 32'hDEADBEEF);
                chk("hs_b_ready", 32'(b_cmd_ready), 32'd1);
        step(); set_a(0, 0, '0, '0, '0); set_b(0, 0, '0, '0, '0);
        look(); chk("hs_b_rdata", b_rsp_rdata, 32'hFFFF5555);

        // reset with buffered response, then tie alternation starting at A
        step(); set_a(1, 1, 14'h20, '0, '0); a_rsp_ready = 0;
        look();
        step(); set_a(0, 0, '0, '0, '0);
        look(); step();
        look(); chk("buf_valid", 32'(a_rsp_valid), 32'd1);
        step(); rst = 1;
        look();
        step(); rst = 0; a_rsp_ready = 1;
        set_a(1, 1, 14'h10, '0, '0); set_b(1, 1, 14'h20, '0, '0);
        look(); chk("post_rst_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
                chk("tie_grant_0", 32'({b_cmd_ready, a_cmd_ready}), 32'd1);
        for (int k = 1; k < 6; k++) begin
            step(); look();
            chk("tie_grant_alt", 32'({b_cmd_ready, a_cmd_ready}), (k % 2) ? 32'd2 : 32'd1);
        end
        step(); set_a(0, 0, '0, '0, '0); set_b(0, 0, '0, '0, '0);
        look();

`ifdef E203_DTCM_RAM_LS_EN
        repeat (20) step();
        look(); chk("sleep_ls", 32'(ram_ls), 32'd1);
        step(); set_b(1, 1, 14'h10, '0, '0);
        look(); chk("sleep_b_rdy", 32'({ram_ls, b_cmd_ready}), 32'd2);
        step();
        look(); chk("wake_b_rdy", 32'({ram_ls, b_cmd_ready}), 32'd0);
        step();
        look(); chk("run_b_acc", 32'({ram_ls, b_cmd_ready, ram_cs}), 32'd3);
        step(); set_b(0, 0, '0, '0, '0);
        look(); chk("wake_rdata", b_rsp_rdata, 32'hDEADBEEF);
        step(); rst = 1;
        step(); rst = 0;
        repeat (15) step();
        look(); chk("idle15_ls", 32'(ram_ls), 32'd0);
        look(); chk("idle16_ls", 32'(ram_ls), 32'd1);
`else
        repeat (100) step();
        look(); chk("nols_idle100", 32'(ram_ls), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e203_dtcm_ram_ctrl.md
E203_DTCM_RAM_CTRL -- requirements
Module: e203_dtcm_ram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 14, meaning RAM word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning RAM data width.
REQ-003 SHALL have parameter MW, default 4, meaning write byte-mask width (DW/8).
REQ-004 SHALL have parameter IDLE_CYC, default 16, meaning idle cycles before light-sleep entry (range 2..255).
REQ-005 SHALL have one clock and synchronous active-high reset: clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 {a,b}_cmd_valid  in  1  requester A/B command valid.
REQ-008 {a,b}_cmd_ready  out  1  command accepted this cycle when high with valid.
REQ-009 {a,b}_cmd_read  in  1  1=read, 0=write.
REQ-010 {a,b}_cmd_addr  in  AW  word address; {a,b}_cmd_wdata  in  DW; {a,b}_cmd_wmask  in  MW.
REQ-011 {a,b}_rsp_valid  out  1; {a,b}_rsp_ready  in  1; {a,b}_rsp_rdata  out  DW (0 for writes).
REQ-012 ram_cs, ram_we  out  1; ram_addr  out  AW; ram_wem  out  MW; ram_din  out  DW; ram_dout  in  DW.
REQ-013 ram_ls  out  1  light-sleep; ram_ds, ram_sd  out  1  tied 0.

Function
REQ-014 At most one RAM access per cycle; ram_cs asserted only in the accept cycle, driven combinationally from the winning command.
REQ-015 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last wins; last-grant register updates only on accept.
REQ-016 Response SHALL appear on the granted requester's rsp_valid exactly 1 cycle after accept, rdata = ram_dout for reads, 0 for writes.
REQ-017 If rsp_ready is low in the response cycle, ram_dout SHALL be captured in a 1-entry response buffer and held stable with rsp_valid until rsp_ready.
REQ-018 While a response is buffered or presented and not yet handshaken, both cmd_ready SHALL be 0 (no new accept); accept in the same cycle as a response handshake is permitted (full throughput 1/cycle when rsp_ready=1).
REQ-019 cmd_ready SHALL not depend on rsp_ready combinationally beyond REQ-018; cmd_ready of the loser is 0.
REQ-020 Power FSM states: RUN, SLEEP, WAKE. RUN: idle counter increments each cycle with no cmd_valid and no pending response, clears otherwise; at IDLE_CYC -> SLEEP.
REQ-021 SLEEP: ram_ls=1, all cmd_ready=0; any cmd_valid -> WAKE. WAKE: ram_ls=0, cmd_ready=0 for exactly 1 cycle -> RUN.
REQ-022 ram_cs SHALL never be 1 while ram_ls=1.

Reset
REQ-023 On rst: state=RUN, idle counter=0, last-grant=B (A wins first tie), response buffer empty, all rsp_valid=0, ram_cs=0, ram_ls=0.
REQ-024 Reset mid-transaction SHALL drop any pending response without delivery.

Configuration
REQ-025 Macro E203_DTCM_RAM_LS_EN: defined -> power FSM per REQ-020..021; undefined -> FSM and counter removed, state fixed RUN, ram_ls tied 0, IDLE_CYC ignored.

Structure
REQ-026 Power-state enum and ram_ls/ds/sd tie constants SHALL live in the shared e203 package.
REQ-027 Round-robin arbiter SHALL be a sub-module e203_dtcm_rr_arb2 (2 requests, grant, update enable).

Verification
REQ-028 A write addr 0x10 data 0xDEADBEEF mask 0xF, then A read 0x10 -> a_rsp_rdata 0xDEADBEEF one cycle after read accept.
REQ-029 A and B valid every cycle, rsp_ready=1 -> grants alternate A,B,A,B, one accept per cycle.
REQ-030 A read, a_rsp_ready=0 for 3 cycles -> rdata held stable, no cmd_ready until handshake cycle.
REQ-031 Idle 16 cycles -> ram_ls=1; B valid -> 1 WAKE cycle, B accepted on the following cycle; no ram_cs while ram_ls=1.
REQ-032 Write mask 0x3 data 0xAAAA5555 over 0xFFFFFFFF -> read returns 0xFFFF5555.
REQ-033 Reset asserted with response buffered -> rsp_valid 0 next cycle, A wins next tie; with E203_DTCM_RAM_LS_EN undefined, 100 idle cycles -> ram_ls stays 0.
